// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared types and defaults for the data RAM arbiter
package data_ram_arbiter_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_LENGTH  = 8;
    localparam int DEF_TIMEOUT = 15;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - requester ports A/B and RAM command/response bundle
interface data_ram_arbiter_if
    import data_ram_arbiter_pkg::*;
#(
    parameter int width  = DEF_WIDTH,
    parameter int length = DEF_LENGTH
);
    logic              a_req, b_req;
    logic              a_we, b_we;
    logic              a_indirect, b_indirect;
    logic [length-1:0] a_addr, b_addr;
    logic [width-1:0]  a_wdata, b_wdata;
    logic              a_gnt, b_gnt;
    logic              a_done, b_done;
    logic              a_err, b_err;
    logic [width-1:0]  a_rdata, b_rdata;

    logic              ram_writeEnable, ram_readEnable, ram_indirect;
    logic [length-1:0] ram_addr;
    logic [width-1:0]  ram_writeData;
    logic              ram_dataReady;
    logic [width-1:0]  ram_readData;

    modport slave (
        input  a_req, b_req, a_we, b_we, a_indirect, b_indirect,
        input  a_addr, b_addr, a_wdata, b_wdata,
        output a_gnt, b_gnt, a_done, b_done, a_err, b_err, a_rdata, b_rdata,
        output ram_writeEnable, ram_readEnable, ram_indirect, ram_addr, ram_writeData,
        input  ram_dataReady, ram_readData
    );

    modport master (
        output a_req, b_req, a_we, b_we, a_indirect, b_indirect,
        output a_addr, b_addr, a_wdata, b_wdata,
        input  a_gnt, b_gnt, a_done, b_done, a_err, b_err, a_rdata, b_rdata,
        input  ram_writeEnable, ram_readEnable, ram_indirect, ram_addr, ram_writeData,
        output ram_dataReady, ram_readData
    );

endinterface

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// rtl/data_ram_arbiter_rr_arbiter2.sv - two-input round-robin pick
module rr_arbiter2
    import data_ram_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner
);

    // On a tie the port that was not granted last wins.
    always_comb begin
        o_winner = PORT_A;
        if (i_req[PORT_B] && (!i_req[PORT_A] || (i_last == PORT_A))) begin
            o_winner = PORT_B;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port (CPU/IO) arbiter in front of a single data RAM
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int width   = DEF_WIDTH,
    parameter int length  = DEF_LENGTH,
    parameter int timeout = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    data_ram_arbiter_if.slave bus
);

    localparam logic [7:0] WAIT_LAST = 8'(timeout - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_winner;
    logic              r_last;
    logic              r_we;
    logic              r_ind;
    logic              r_err;
    logic [length-1:0] r_addr;
    logic [width-1:0]  r_wdata;
    logic [width-1:0]  r_a_rdata;
    logic [width-1:0]  r_b_rdata;
    logic [7:0]        r_cnt;

    logic w_pick;
    logic w_any_req;
    logic w_issue;
    logic w_resp;
    logic w_timeout;

    assign w_any_req = bus.a_req | bus.b_req;

    rr_arbiter2 u_rr (
        .i_req    ({bus.b_req, bus.a_req}),
        .i_last   (r_last),
        .o_winner (w_pick)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:  if (w_any_req) w_next = ISSUE;
            ISSUE: w_next = r_we ? RESP : WAIT;
            WAIT: begin
                if (bus.ram_dataReady) begin
                    w_next = RESP;
                end else if (r_cnt == WAIT_LAST) begin
                    w_next    = RESP;
                    w_timeout = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so the loser cannot disturb the transaction.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_winner  <= PORT_A;
            r_last    <= PORT_B;
            r_we      <= 1'b0;
            r_ind     <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_pick;
                        r_we     <= (w_pick == PORT_B) ? bus.b_we       : bus.a_we;
                        r_ind    <= (w_pick == PORT_B) ? bus.b_indirect : bus.a_indirect;
                        r_addr   <= (w_pick == PORT_B) ? bus.b_addr     : bus.a_addr;
                        r_wdata  <= (w_pick == PORT_B) ? bus.b_wdata    : bus.a_wdata;
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                WAIT: begin
                    if (bus.ram_dataReady) begin
                        if (r_winner == PORT_B) r_b_rdata <= bus.ram_readData;
                        else                    r_a_rdata <= bus.ram_readData;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: r_last <= r_winner;
                default: ;
            endcase
        end
    end

    assign w_issue = (r_state == ISSUE);
    assign w_resp  = (r_state == RESP);

    assign bus.a_gnt  = w_issue && (r_winner == PORT_A);
    assign bus.b_gnt  = w_issue && (r_winner == PORT_B);
    assign bus.a_done = w_resp && (r_winner == PORT_A);
    assign bus.b_done = w_resp && (r_winner == PORT_B);
    assign bus.a_err  = w_resp && (r_winner == PORT_A) && r_err;
    assign bus.b_err  = w_resp && (r_winner == PORT_B) && r_err;

    assign bus.a_rdata = r_a_rdata;
    assign bus.b_rdata = r_b_rdata;

    assign bus.ram_writeEnable = w_issue && r_we;
    assign bus.ram_readEnable  = w_issue && !r_we;
    assign bus.ram_indirect    = w_issue && r_ind && !r_we;
    assign bus.ram_addr        = r_addr;
    assign bus.ram_writeData   = r_wdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - randomized self-checking bench with transaction-level reference model
module tb_data_ram_arbiter;

    localparam int W    = 8;
    localparam int L    = 8;
    localparam int TO   = 15;
    localparam int MAXC = 256;

    typedef struct {
        logic       we;
        logic       ind;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         dly;
    } txn_t;

    logic clk;
    logic clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_ram_arbiter_if #(.width(W), .length(L)) bus ();

    data_ram_arbiter #(.width(W), .length(L), .timeout(TO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] m_rd    [2];
    int         m_last;
    txn_t       qa[$];
    txn_t       qb[$];
    int         busy;
    int         rcnt;
    logic [7:0] rval;

    logic [1:0] e_gnt  [MAXC];
    logic [1:0] e_done [MAXC];
    logic [1:0] e_err  [MAXC];
    logic [2:0] e_cmd  [MAXC];
    logic [7:0] e_addr [MAXC];
    logic [7:0] e_wd   [MAXC];
    logic [7:0] e_rd   [MAXC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [40:0] outs();
        return {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.a_err, bus.b_err,
                bus.a_rdata, bus.b_rdata, bus.ram_writeEnable, bus.ram_readEnable,
                bus.ram_indirect, bus.ram_addr, bus.ram_writeData};
    endfunction

    function automatic txn_t mk(input logic we, input logic ind, input logic [7:0] addr,
                                input logic [7:0] wdata, input int dly);
        txn_t t;
        t.we = we; t.ind = ind; t.addr = addr; t.wdata = wdata; t.dly = dly;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.ind   = 1'($urandom_range(0, 1));
        t.addr  = 8'($urandom_range(0, 15));
        t.wdata = 8'($urandom_range(0, 31));
        t.dly   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
        return t;
    endfunction

    task automatic drive_ports();
        if (qa.size() > 0) begin
            bus.a_req = 1'b1; bus.a_we = qa[0].we; bus.a_indirect = qa[0].ind;
            bus.a_addr = qa[0].addr; bus.a_wdata = qa[0].wdata;
        end else begin
            bus.a_req = 1'b0; bus.a_we = 1'($urandom); bus.a_indirect = 1'($urandom);
            bus.a_addr = 8'($urandom); bus.a_wdata = 8'($urandom);
        end
        if (qb.size() > 0) begin
            bus.b_req = 1'b1; bus.b_we = qb[0].we; bus.b_indirect = qb[0].ind;
            bus.b_addr = qb[0].addr; bus.b_wdata = qb[0].wdata;
        end else begin
            bus.b_req = 1'b0; bus.b_we = 1'($urandom); bus.b_indirect = 1'($urandom);
            bus.b_addr = 8'($urandom); bus.b_wdata = 8'($urandom);
        end
    endtask

    // RAM behaviour seen from the bench side; called once per cycle at the falling edge.
    task automatic ram_step();
        txn_t t;
        if (bus.a_done || bus.b_done) busy = 0;
        if (bus.ram_writeEnable) ram[bus.ram_addr] = bus.ram_writeData;
        if (bus.ram_readEnable) begin
            t    = bus.a_gnt ? qa[0] : qb[0];
            busy = 1;
            rcnt = t.dly;
            rval = bus.ram_indirect ? ram[ram[bus.ram_addr]] : ram[bus.ram_addr];
            bus.ram_dataReady = 1'b0;
            bus.ram_readData  = 8'($urandom);
        end else if (busy != 0) begin
            if (rcnt == 0) begin
                bus.ram_dataReady = 1'b1;
                bus.ram_readData  = rval;
                busy = 0;
            end else begin
                bus.ram_dataReady = 1'b0;
                bus.ram_readData  = 8'($urandom);
                if (rcnt > 0) rcnt--;
            end
        end else begin
            bus.ram_dataReady = 1'($urandom_range(0, 1));
            bus.ram_readData  = 8'($urandom);
        end
    endtask

    // Plans the whole exchange from service times (write 3, read 4+delay, timeout 3+TO cycles),
    // then steps the DUT cycle by cycle against the plan. abort_at>0 pulls clr low in that cycle.
    task automatic run(input int abort_at);
        txn_t       ma[$];
        txn_t       mb[$];
        txn_t       tx;
        int         t, dn, w, t_end;
        logic [1:0] pb;
        bit         aborted;
        for (int i = 0; i < MAXC; i++) begin
            e_gnt[i] = '0; e_done[i] = '0; e_err[i] = '0; e_cmd[i] = '0;
            e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
        end
        ma = qa; mb = qb; t = 0; t_end = 0;
        while (ma.size() > 0 || mb.size() > 0) begin
            if (ma.size() > 0 && mb.size() > 0) w = (m_last == 0) ? 1 : 0;
            else                                w = (ma.size() > 0) ? 0 : 1;
            tx = (w == 0) ? ma.pop_front() : mb.pop_front();
            pb = (w == 0) ? 2'b10 : 2'b01;
            e_gnt[t+1]  = pb;
            e_cmd[t+1]  = {tx.we, !tx.we, tx.ind & !tx.we};
            e_addr[t+1] = tx.addr;
            e_wd[t+1]   = tx.wdata;
            if (tx.we) begin
                dn = t + 2;
                ref_mem[tx.addr] = tx.wdata;
            end else if (tx.dly >= 0 && tx.dly < TO) begin
                dn = t + 3 + tx.dly;
                m_rd[w] = tx.ind ? ref_mem[ref_mem[tx.addr]] : ref_mem[tx.addr];
            end else begin
                dn = t + 2 + TO;
                e_err[dn] = pb;
            end
            e_done[dn] = pb;
            e_rd[dn]   = m_rd[w];
            m_last = w;
            t      = dn + 1;
            t_end  = dn;
        end

        aborted = 0;
        drive_ports();
        for (int c = 1; c <= t_end + 1; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                clr = 1'b0;
                #1;
                check("reset_outs_async", 64'(outs()), 64'd0);
                aborted = 1;
                break;
            end
            check("gnt", 64'({bus.a_gnt, bus.b_gnt}), 64'(e_gnt[c]));
            check("done", 64'({bus.a_done, bus.b_done}), 64'(e_done[c]));
            check("err", 64'({bus.a_err, bus.b_err}), 64'(e_err[c]));
            check("ram_cmd", 64'({bus.ram_writeEnable, bus.ram_readEnable, bus.ram_indirect}), 64'(e_cmd[c]));
            if (e_cmd[c] != 3'b000) check("ram_addr", 64'(bus.ram_addr), 64'(e_addr[c]));
            if (e_cmd[c][2])        check("ram_wdata", 64'(bus.ram_writeData), 64'(e_wd[c]));
            if (e_done[c][1])       check("a_rdata", 64'(bus.a_rdata), 64'(e_rd[c]));
            if (e_done[c][0])       check("b_rdata", 64'(bus.b_rdata), 64'(e_rd[c]));
            ram_step();
            if (bus.a_gnt) void'(qa.pop_front());
            if (bus.b_gnt) void'(qb.pop_front());
            drive_ports();
        end

        if (aborted) begin
            @(negedge clk);
            check("reset_outs_held", 64'(outs()), 64'd0);
            clr = 1'b1;
            qa.delete(); qb.delete();
            drive_ports();
            busy = 0;
            bus.ram_dataReady = 1'b0;
            m_last = 1;
            m_rd[0] = '0; m_rd[1] = '0;
            repeat (3) begin
                @(negedge clk);
                check("no_done_after_reset", 64'({bus.a_done, bus.b_done, bus.a_gnt, bus.b_gnt}), 64'd0);
            end
        end else begin
            check("a_rdata_hold", 64'(bus.a_rdata), 64'(m_rd[0]));
            check("b_rdata_hold", 64'(bus.b_rdata), 64'(m_rd[1]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        m_last = 1;
        m_rd[0] = '0; m_rd[1] = '0;
        busy = 0; rcnt = 0; rval = '0;
        bus.ram_dataReady = 1'b0;
        bus.ram_readData  = '0;
        drive_ports();

        clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 64'(outs()), 64'd0);
        clr = 1'b1;

        // write 0x5A to 0x10 then read it back on port A
        qa.push_back(mk(1'b1, 1'b0, 8'h10, 8'h5A, 0));
        qa.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00, 0));
        run(0);
        check("a_rdata_5a", 64'(bus.a_rdata), 64'h5A);

        // indirect read through RAM[0x20]=0x30, RAM[0x30]=0xC3 on port B
        qa.push_back(mk(1'b1, 1'b0, 8'h20, 8'h30, 0));
        qa.push_back(mk(1'b1, 1'b0, 8'h30, 8'hC3, 0));
        run(0);
        qb.push_back(mk(1'b0, 1'b1, 8'h20, 8'h00, 1));
        run(0);
        check("b_rdata_c3", 64'(bus.b_rdata), 64'hC3);

        // both ports requesting continuously: grants A, B, A
        qa.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00, 0));
        qa.push_back(mk(1'b1, 1'b0, 8'h40, 8'h11, 0));
        qb.push_back(mk(1'b1, 1'b0, 8'h41, 8'h22, 0));
        run(0);

        // read timeout on port B leaves b_rdata unchanged
        qb.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00, -1));
        run(0);
        check("b_rdata_after_timeout", 64'(bus.b_rdata), 64'hC3);

        // back-to-back A-only writes
        for (int i = 0; i < 3; i++) qa.push_back(mk(1'b1, 1'b0, 8'(8'h60 + i), 8'(8'hA0 + i), 0));
        run(0);

        // reset during WAIT after A was granted last; the next tie must favour A
        qa.push_back(mk(1'b1, 1'b0, 8'h50, 8'h77, 0));
        run(0);
        qb.push_back(mk(1'b0, 1'b0, 8'h50, 8'h00, -1));
        run(6);
        qa.push_back(mk(1'b1, 1'b0, 8'h51, 8'h01, 0));
        qb.push_back(mk(1'b1, 1'b0, 8'h52, 8'h02, 0));
        run(0);

        for (int r = 0; r < 25; r++) begin
            int na, nb;
            na = int'($urandom_range(0, 2));
            nb = int'($urandom_range(0, 2));
            if (na == 0 && nb == 0) na = 1;
            for (int i = 0; i < na; i++) qa.push_back(rand_txn());
            for (int i = 0; i < nb; i++) qb.push_back(rand_txn());
            run(0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
